// File: rtl/snes_bus_sync.sv
// Synchronises and glitch-filters the raw SNES cartridge bus into clean event pulses and a bus phase.
// Optional stopped-clock detection is built when SNES_DEAD_DETECT_EN is defined.
module snes_bus_sync #(
    parameter int ADDR_W       = 24,
    parameter int DEAD_TIMEOUT = 88000,
    parameter int DEAD_CNT_W   = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] snes_addr_in,
    input  logic              snes_read,
    input  logic              snes_write,
    input  logic              snes_pard,
    input  logic              snes_pawr,
    input  logic              snes_cpu_clk,
    output logic [ADDR_W-1:0] snes_addr,
    output logic [ADDR_W-1:0] snes_addr_lat,
    output logic              cycle_start,
    output logic              cycle_end,
    output logic              rd_start,
    output logic              wr_start,
    output logic              wr_end,
    output logic              pard_start,
    output logic              pawr_start,
    output logic [1:0]        bus_phase,
    output logic [15:0]       cycle_cnt,
    output logic              err_overlap,
    output logic              snes_dead
);

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_READ  = 2'd1,
        PH_WRITE = 2'd2,
        PH_DEAD  = 2'd3
    } phase_t;

    phase_t phase;

    logic [ADDR_W-1:0] addr_r0;
    logic [ADDR_W-1:0] addr_r1;
    logic [ADDR_W-1:0] addr_r2;

    // Sample histories, bit 0 is the newest sample.
    logic [7:0] rd_h;
    logic [7:0] wr_h;
    logic [7:0] pard_h;
    logic [7:0] pawr_h;
    logic [7:0] cpu_h;
    logic [5:0] cpu_f;

    // A bit of cpu_f is set only where two adjacent samples were both high,
    // so an isolated one-sample high never looks like a clock edge.
    assign cpu_f     = cpu_h[7:2] & cpu_h[6:1];
    assign bus_phase = phase;

    if (DEAD_TIMEOUT >= (1 << DEAD_CNT_W)) begin : g_cnt_w_check
        $error("DEAD_CNT_W is too narrow to hold DEAD_TIMEOUT");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r0       <= '0;
            addr_r1       <= '0;
            addr_r2       <= '0;
            snes_addr     <= '0;
            snes_addr_lat <= '0;
            rd_h          <= 8'hFF;
            wr_h          <= 8'hFF;
            pard_h        <= 8'hFF;
            pawr_h        <= 8'hFF;
            cpu_h         <= 8'h00;
            cycle_start   <= 1'b0;
            cycle_end     <= 1'b0;
            rd_start      <= 1'b0;
            wr_start      <= 1'b0;
            wr_end        <= 1'b0;
            pard_start    <= 1'b0;
            pawr_start    <= 1'b0;
            cycle_cnt     <= 16'd0;
            err_overlap   <= 1'b0;
            phase         <= PH_IDLE;
        end else begin
            addr_r0   <= snes_addr_in;
            addr_r1   <= addr_r0;
            addr_r2   <= addr_r1;
            snes_addr <= addr_r2 & addr_r1;

            rd_h   <= {rd_h[6:0], snes_read};
            wr_h   <= {wr_h[6:0], snes_write};
            pard_h <= {pard_h[6:0], snes_pard};
            pawr_h <= {pawr_h[6:0], snes_pawr};
            cpu_h  <= {cpu_h[6:0], snes_cpu_clk};

            rd_start    <= (rd_h[7:1] == 7'b1111110);
            wr_start    <= (wr_h[7:1] == 7'b1111110);
            wr_end      <= (wr_h[7:1] == 7'b0000001);
            pard_start  <= (pard_h[7:1] == 7'b1111110);
            pawr_start  <= (pawr_h[7:1] == 7'b1111110);
            cycle_start <= (cpu_f == 6'b000001);
            cycle_end   <= (cpu_f == 6'b111110);

            // A stopped clock overrides everything, including a pending cycle_start.
            if (snes_dead) begin
                phase <= PH_DEAD;
            end else if (phase == PH_DEAD) begin
                phase <= PH_IDLE;
            end else if (cycle_start) begin
                if (phase != PH_IDLE) begin
                    err_overlap <= 1'b1;
                end
                snes_addr_lat <= snes_addr;
                cycle_cnt     <= cycle_cnt + 16'd1;
                phase         <= wr_h[0] ? PH_READ : PH_WRITE;
            end else if (cycle_end && (phase != PH_IDLE)) begin
                phase <= PH_IDLE;
            end
        end
    end

`ifdef SNES_DEAD_DETECT_EN
    localparam logic [DEAD_CNT_W-1:0] DEAD_LIM = DEAD_CNT_W'(DEAD_TIMEOUT);

    logic [DEAD_CNT_W-1:0] dead_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            dead_cnt  <= '0;
            snes_dead <= 1'b0;
        end else if (cpu_h[0]) begin
            dead_cnt  <= '0;
            snes_dead <= 1'b0;
        end else begin
            if (dead_cnt != '1) begin
                dead_cnt <= dead_cnt + 1'b1;
            end
            if (dead_cnt > DEAD_LIM) begin
                snes_dead <= 1'b1;
            end
        end
    end
`else
    assign snes_dead = 1'b0;
`endif

endmodule

// File: tb/tb_snes_bus_sync.sv
// Randomised bench for snes_bus_sync: every output is compared each cycle against a
// model that evaluates the edge/phase rules directly on the log of sampled input levels.
module tb_snes_bus_sync;

    localparam int AW    = 24;
    localparam int T     = 100;
    localparam int DEPTH = 16384;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] snes_addr_in;
    logic          snes_read, snes_write, snes_pard, snes_pawr, snes_cpu_clk;
    logic [AW-1:0] snes_addr, snes_addr_lat;
    logic          cycle_start, cycle_end, rd_start, wr_start, wr_end, pard_start, pawr_start;
    logic [1:0]    bus_phase;
    logic [15:0]   cycle_cnt;
    logic          err_overlap, snes_dead;

    always #5 clk = ~clk;

    snes_bus_sync #(.ADDR_W(AW), .DEAD_TIMEOUT(T), .DEAD_CNT_W(18)) dut (
        .clk(clk), .rst(rst), .snes_addr_in(snes_addr_in),
        .snes_read(snes_read), .snes_write(snes_write), .snes_pard(snes_pard),
        .snes_pawr(snes_pawr), .snes_cpu_clk(snes_cpu_clk),
        .snes_addr(snes_addr), .snes_addr_lat(snes_addr_lat),
        .cycle_start(cycle_start), .cycle_end(cycle_end), .rd_start(rd_start),
        .wr_start(wr_start), .wr_end(wr_end), .pard_start(pard_start),
        .pawr_start(pawr_start), .bus_phase(bus_phase), .cycle_cnt(cycle_cnt),
        .err_overlap(err_overlap), .snes_dead(snes_dead)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Input levels seen at each clock edge since the last reset (index 0 = first edge).
    logic          ck_a[DEPTH];
    logic          rd_a[DEPTH];
    logic          wr_a[DEPTH];
    logic          pd_a[DEPTH];
    logic          pw_a[DEPTH];
    logic [AW-1:0] ad_a[DEPTH];
    int            n;

    // which: 0 cpu_clk, 1 read, 2 write, 3 pard, 4 pawr. Before reset release the
    // strobes read as high and the CPU clock as low.
    function automatic logic samp(input int which, input int m);
        if (m < 1) return (which == 0) ? 1'b0 : 1'b1;
        case (which)
            0:       return ck_a[m-1];
            1:       return rd_a[m-1];
            2:       return wr_a[m-1];
            3:       return pd_a[m-1];
            default: return pw_a[m-1];
        endcase
    endfunction

    function automatic logic [AW-1:0] addr_at(input int m);
        if (m < 1) return '0;
        return ad_a[m-1];
    endfunction

    // Falling edge visible after edge e: the sample at e-2 is low and e-3..e-8 were high.
    function automatic logic fell(input int which, input int e);
        if (samp(which, e - 2) !== 1'b0) return 1'b0;
        for (int k = 3; k <= 8; k++) if (samp(which, e - k) !== 1'b1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic wr_rose(input int e);
        if (samp(2, e - 2) !== 1'b1) return 1'b0;
        for (int k = 3; k <= 8; k++) if (samp(2, e - k) !== 1'b0) return 1'b0;
        return 1'b1;
    endfunction

    // Bit j is "two consecutive high samples" (j=0 the most recent pair ending at e-2).
    function automatic logic [5:0] cpu_pairs(input int e);
        logic [5:0] f;
        for (int j = 0; j < 6; j++) f[j] = samp(0, e - 3 - j) & samp(0, e - 2 - j);
        return f;
    endfunction

    // Reference model state
    int          m_phase;
    logic [AW-1:0] m_lat;
    logic [15:0] m_cnt;
    logic        m_err;
    int          m_zero_run;
    logic        p_cs, p_ce, p_dead;
    logic [AW-1:0] p_addr;
    logic [AW-1:0] exp_q[$];

    task automatic model_reset();
        n = 0; m_phase = 0; m_lat = '0; m_cnt = '0; m_err = 1'b0; m_zero_run = 0;
        p_cs = 1'b0; p_ce = 1'b0; p_dead = 1'b0; p_addr = '0;
        exp_q.delete();
    endtask

    task automatic step();
        logic e_cs, e_ce, e_rd, e_wr, e_we, e_pd, e_pw, e_dead;
        logic [AW-1:0] e_addr;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            n++;
            if (n > DEPTH) begin
                $display("FAIL log_depth got=%0d exp=%0d", n, DEPTH);
                $fatal(1, "sample log overflow");
            end
            ck_a[n-1] = snes_cpu_clk; rd_a[n-1] = snes_read; wr_a[n-1] = snes_write;
            pd_a[n-1] = snes_pard; pw_a[n-1] = snes_pawr; ad_a[n-1] = snes_addr_in;
            // Bus phase reacts to what was visible on the outputs after the previous edge.
            if (p_dead) begin
                m_phase = 3;
            end else if (m_phase == 3) begin
                m_phase = 0;
            end else if (p_cs) begin
                if (m_phase != 0) m_err = 1'b1;
                m_lat = p_addr;
                m_cnt = m_cnt + 16'd1;
                m_phase = (samp(2, n - 1) == 1'b0) ? 2 : 1;
                exp_q.push_back(m_lat);
            end else if (p_ce && m_phase != 0) begin
                m_phase = 0;
            end
            if (samp(0, n - 1) == 1'b0) m_zero_run++; else m_zero_run = 0;
        end
        e_cs   = (n > 0) && (cpu_pairs(n) == 6'b000001);
        e_ce   = (n > 0) && (cpu_pairs(n) == 6'b111110);
        e_rd   = (n > 0) && fell(1, n);
        e_wr   = (n > 0) && fell(2, n);
        e_pd   = (n > 0) && fell(3, n);
        e_pw   = (n > 0) && fell(4, n);
        e_we   = (n > 0) && wr_rose(n);
        e_addr = (n > 0) ? (addr_at(n - 2) & addr_at(n - 3)) : '0;
`ifdef SNES_DEAD_DETECT_EN
        e_dead = (m_zero_run >= T + 2);
`else
        e_dead = 1'b0;
`endif
        p_cs = e_cs; p_ce = e_ce; p_dead = e_dead; p_addr = e_addr;
        #1;
        check_eq("cycle_start", cycle_start, e_cs);
        check_eq("cycle_end", cycle_end, e_ce);
        check_eq("rd_start", rd_start, e_rd);
        check_eq("wr_start", wr_start, e_wr);
        check_eq("wr_end", wr_end, e_we);
        check_eq("pard_start", pard_start, e_pd);
        check_eq("pawr_start", pawr_start, e_pw);
        check_eq("snes_addr", snes_addr, e_addr);
        check_eq("snes_addr_lat", snes_addr_lat, m_lat);
        check_eq("bus_phase", bus_phase, m_phase);
        check_eq("cycle_cnt", cycle_cnt, m_cnt);
        check_eq("err_overlap", err_overlap, m_err);
        check_eq("snes_dead", snes_dead, e_dead);
        if (exp_q.size() > 0) check_eq("lat_event", snes_addr_lat, exp_q.pop_front());
    endtask

    task automatic hold(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    // Random stimulus: each strobe keeps its level for a random run, the address
    // changes occasionally and sometimes shows a one-sample glitch.
    int            hold_cnt[5];
    logic [AW-1:0] addr_base;
    logic          glitch;

    task automatic rand_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            for (int k = 0; k < 5; k++) begin
                if (hold_cnt[k] == 0) begin
                    case (k)
                        0: snes_cpu_clk = ~snes_cpu_clk;
                        1: snes_read    = ~snes_read;
                        2: snes_write   = ~snes_write;
                        3: snes_pard    = ~snes_pard;
                        default: snes_pawr = ~snes_pawr;
                    endcase
                    hold_cnt[k] = (k == 0) ? $urandom_range(1, 9) : $urandom_range(1, 11);
                end else begin
                    hold_cnt[k]--;
                end
            end
            if (glitch) begin
                snes_addr_in = addr_base;
                glitch = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                snes_addr_in = addr_base ^ (AW'(1) << $urandom_range(0, AW - 1));
                glitch = 1'b1;
            end else begin
                if ($urandom_range(0, 7) == 0) addr_base = AW'($urandom);
                snes_addr_in = addr_base;
            end
            step();
        end
    endtask

    initial begin
        model_reset();
        for (int k = 0; k < 5; k++) hold_cnt[k] = 0;
        addr_base = '0; glitch = 1'b0;
        rst = 1'b1; snes_addr_in = '0;
        snes_read = 1'b1; snes_write = 1'b1; snes_pard = 1'b1; snes_pawr = 1'b1;
        snes_cpu_clk = 1'b0;
        step(); step();
        rst = 1'b0;
        hold(20);

        // Read cycle at C08000
        snes_addr_in = 24'hC08000;
        snes_cpu_clk = 1'b1; hold(6);
        snes_cpu_clk = 1'b0; hold(10);

        // Write cycle: WRITE falls two samples before the clock rise
        snes_write = 1'b0; hold(2);
        snes_cpu_clk = 1'b1; hold(6);
        snes_cpu_clk = 1'b0; snes_write = 1'b1; hold(10);

        // One-sample clock glitch, then a one-sample address glitch on bit 0
        snes_cpu_clk = 1'b1; hold(1);
        snes_cpu_clk = 1'b0; hold(10);
        snes_addr_in = 24'hC08001; hold(1);
        snes_addr_in = 24'hC08000; hold(10);

        // Stopped clock, then recovery
        hold(T + 8);
        snes_cpu_clk = 1'b1; hold(8);
        snes_cpu_clk = 1'b0; hold(8);

        // Second rise before any cycle_end
        snes_cpu_clk = 1'b1; hold(3);
        snes_cpu_clk = 1'b0; hold(4);
        snes_cpu_clk = 1'b1; hold(8);
        snes_cpu_clk = 1'b0; hold(12);

        rand_run(1500);

        // Reset in the middle of random activity
        rst = 1'b1; step();
        rst = 1'b0;
        rand_run(1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
